// File: rtl/cam_cmd_sequencer.sv
// CAM command sequencer: one command in flight, response 2 cycles after accept (plus strobe/tag wait), held until rsp_ready.
// Optional macro CAM_SEQ_SET_TIMEOUT_EN bounds the SET_HIGH tag wait and reports expiry as an error response.
module cam_cmd_sequencer #(
  parameter int NUM_BITS      = 32,
  parameter int NUM_CELLS     = 16,
  parameter int SEARCH_CYCLES = 10,
  parameter int SELECT_CYCLES = 5,
  parameter int WRITE_CYCLES  = 5,
  parameter int SET_TIMEOUT   = 1024
) (
  input  logic                  clk_48mhz,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_op,
  input  logic [NUM_BITS-1:0]   cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [NUM_BITS-1:0]   rsp_data,
  output logic                  rsp_err,
  output logic [NUM_BITS-1:0]   comparand,
  output logic [NUM_BITS-1:0]   mask,
  output logic                  perform_search,
  output logic                  set_line,
  output logic                  select_first,
  output logic [2*NUM_BITS-1:0] write_lines,
  input  logic [NUM_CELLS-1:0]  tag_wires,
  input  logic [NUM_BITS-1:0]   read_lines
);

  localparam logic [3:0] OP_SET_COMPARAND = 4'd1;
  localparam logic [3:0] OP_SET_MASK      = 4'd2;
  localparam logic [3:0] OP_SEARCH        = 4'd3;
  localparam logic [3:0] OP_SELECT_FIRST  = 4'd4;
  localparam logic [3:0] OP_SET_HIGH      = 4'd5;
  localparam logic [3:0] OP_SET_LOW       = 4'd6;
  localparam logic [3:0] OP_WRITE         = 4'd7;
  localparam logic [3:0] OP_READ          = 4'd8;
  localparam logic [3:0] OP_GET_TAGS      = 4'd9;
  localparam logic [3:0] OP_GET_COMPARAND = 4'd10;
  localparam logic [3:0] OP_GET_MASK      = 4'd11;

  // Zero-length pulses would be invisible to the CAM clock, so they are stretched to one cycle.
  localparam int SEARCH_N  = (SEARCH_CYCLES < 1) ? 1 : SEARCH_CYCLES;
  localparam int SELECT_N  = (SELECT_CYCLES < 1) ? 1 : SELECT_CYCLES;
  localparam int WRITE_N   = (WRITE_CYCLES  < 1) ? 1 : WRITE_CYCLES;
  localparam int MAX_SS    = (SEARCH_N > SELECT_N) ? SEARCH_N : SELECT_N;
  localparam int PULSE_MAX = (MAX_SS > WRITE_N) ? MAX_SS : WRITE_N;
  localparam int CNT_W     = $clog2(PULSE_MAX + 1);

  localparam logic [CNT_W-1:0] SEARCH_LD = CNT_W'(SEARCH_N - 1);
  localparam logic [CNT_W-1:0] SELECT_LD = CNT_W'(SELECT_N - 1);
  localparam logic [CNT_W-1:0] WRITE_LD  = CNT_W'(WRITE_N - 1);

  typedef enum logic [2:0] {IDLE, EXEC, PULSE, WAIT_TAGS, RESP} state_t;

  state_t                state, state_nxt;
  logic [3:0]            op_q;
  logic [NUM_BITS-1:0]   data_q;
  logic [CNT_W-1:0]      pulse_cnt;
  logic [NUM_BITS-1:0]   tags_ext;
  logic [2*NUM_BITS-1:0] wr_pattern;
  logic                  tags_full;
  logic                  tmo_hit;

`ifdef CAM_SEQ_SET_TIMEOUT_EN
  localparam int TMO_N = (SET_TIMEOUT < 1) ? 1 : SET_TIMEOUT;
  localparam int TMO_W = $clog2(TMO_N + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_N - 1);
  logic [TMO_W-1:0] tmo_cnt;
  assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  assign cmd_ready = reset_n && (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign tags_full = &tag_wires;

  always_comb begin
    tags_ext = '0;
    tags_ext[NUM_CELLS-1:0] = tag_wires;
  end

  // Each cell gets a dual-rail pair: even line writes a 1, odd line writes a 0; masked-off cells stay untouched.
  always_comb begin
    wr_pattern = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      wr_pattern[2*i]   = comparand[i] & mask[i];
      wr_pattern[2*i+1] = ~comparand[i] & mask[i];
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (cmd_valid && cmd_ready) state_nxt = EXEC;
      EXEC: begin
        case (op_q)
          OP_SEARCH, OP_SELECT_FIRST, OP_WRITE: state_nxt = PULSE;
          OP_SET_HIGH:                          state_nxt = WAIT_TAGS;
          default:                              state_nxt = RESP;
        endcase
      end
      PULSE:     if (pulse_cnt == '0) state_nxt = RESP;
      WAIT_TAGS: if (tags_full || tmo_hit) state_nxt = RESP;
      RESP:      if (rsp_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      op_q           <= '0;
      data_q         <= '0;
      comparand      <= '0;
      mask           <= '0;
      perform_search <= 1'b0;
      select_first   <= 1'b0;
      set_line       <= 1'b0;
      write_lines    <= '0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
      pulse_cnt      <= '0;
`ifdef CAM_SEQ_SET_TIMEOUT_EN
      tmo_cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
          end
        end
        EXEC: begin
          case (op_q)
            OP_SET_COMPARAND: comparand <= data_q;
            OP_SET_MASK:      mask      <= data_q;
            OP_SEARCH: begin
              perform_search <= 1'b1;
              pulse_cnt      <= SEARCH_LD;
            end
            OP_SELECT_FIRST: begin
              select_first <= 1'b1;
              pulse_cnt    <= SELECT_LD;
            end
            OP_WRITE: begin
              write_lines <= wr_pattern;
              pulse_cnt   <= WRITE_LD;
            end
            OP_SET_HIGH: begin
              set_line <= 1'b1;
`ifdef CAM_SEQ_SET_TIMEOUT_EN
              tmo_cnt  <= '0;
`endif
            end
            OP_SET_LOW:       set_line <= 1'b0;
            OP_READ:          rsp_data <= read_lines;
            OP_GET_TAGS:      rsp_data <= tags_ext;
            OP_GET_COMPARAND: rsp_data <= comparand;
            OP_GET_MASK:      rsp_data <= mask;
            default:          rsp_err  <= (op_q > OP_GET_MASK);
          endcase
        end
        PULSE: begin
          if (pulse_cnt == '0) begin
            perform_search <= 1'b0;
            select_first   <= 1'b0;
            write_lines    <= '0;
          end else begin
            pulse_cnt <= pulse_cnt - CNT_W'(1);
          end
        end
        WAIT_TAGS: begin
`ifdef CAM_SEQ_SET_TIMEOUT_EN
          // On expiry set_line is left high; the host decides whether to SET_LOW.
          if (!tags_full) begin
            if (tmo_hit) begin
              rsp_err  <= 1'b1;
              rsp_data <= tags_ext;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
